// File: rtl/rrp_mult_arb_if.sv
// Handshake bundle between the requesters, the rRp_mult datapath and the result consumer.
// The arbiter uses the slave view; the environment drives the master view.
interface rrp_mult_arb_if #(
    parameter int WIDTH = 4,
    parameter int RADIX = 4
);
    localparam int D  = $clog2(RADIX) + 1;
    localparam int XW = D * WIDTH;
    localparam int PW = D * (2 * WIDTH + 1);

    logic          req0_valid;
    logic          req0_ready;
    logic [XW-1:0] req0_x;
    logic [XW-1:0] req0_y;
    logic          req1_valid;
    logic          req1_ready;
    logic [XW-1:0] req1_x;
    logic [XW-1:0] req1_y;
    logic [XW-1:0] mul_x;
    logic [XW-1:0] mul_y;
    logic [PW-1:0] mul_p;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [PW-1:0] rsp_p;
    logic          rsp_id;

    modport slave (
        input  req0_valid, req0_x, req0_y,
        input  req1_valid, req1_x, req1_y,
        input  mul_p, rsp_ready,
        output req0_ready, req1_ready,
        output mul_x, mul_y,
        output rsp_valid, rsp_p, rsp_id
    );

    modport master (
        output req0_valid, req0_x, req0_y,
        output req1_valid, req1_x, req1_y,
        output mul_p, rsp_ready,
        input  req0_ready, req1_ready,
        input  mul_x, mul_y,
        input  rsp_valid, rsp_p, rsp_id
    );
endinterface

// File: rtl/rrp_mult_arb.sv
// Two-requester round-robin, credit-gated issue scheduler for the rRp_mult pipeline.
// Optional feature macro RRP_ARB_PERF_CNT_EN adds issue_cnt/stall_cnt outputs.
module rrp_mult_arb #(
    parameter int WIDTH      = 4,
    parameter int RADIX      = 4,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
`ifdef RRP_ARB_PERF_CNT_EN
    output logic [31:0] issue_cnt,
    output logic [31:0] stall_cnt,
`endif
    rrp_mult_arb_if.slave bus
);
    localparam int D  = $clog2(RADIX) + 1;
    localparam int XW = D * WIDTH;
    localparam int PW = D * (2 * WIDTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = $clog2(FIFO_DEPTH + 1);
    localparam int CW = $clog2(FIFO_DEPTH + LATENCY + 1);

    typedef struct packed {
        logic [PW-1:0] p;
        logic          id;
    } entry_t;

    logic               rr_q, rr_d;
    logic [XW-1:0]      mul_x_q, mul_x_d;
    logic [XW-1:0]      mul_y_q, mul_y_d;
    logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [LATENCY-1:0] tag_id_q, tag_id_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]      count_q, count_d;
    entry_t             mem_q [FIFO_DEPTH];
    entry_t             mem_d [FIFO_DEPTH];

    logic [CW-1:0] inflight;
    logic          credit_ok;
    logic          gnt0, gnt1, grant;
    logic          push, pop;
    entry_t        head;

    // Credit counts products already owed to the FIFO, so a pop frees a slot only next cycle.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + CW'(tag_vld_q[i]);
        end
    end

    assign credit_ok = !reset && ((CW'(count_q) + inflight) < CW'(FIFO_DEPTH));
    assign gnt0      = credit_ok && bus.req0_valid && (!bus.req1_valid || !rr_q);
    assign gnt1      = credit_ok && bus.req1_valid && (!bus.req0_valid ||  rr_q);
    assign grant     = gnt0 || gnt1;

    assign push = tag_vld_q[LATENCY-1];
    assign pop  = bus.rsp_valid && bus.rsp_ready;
    assign head = mem_q[rd_ptr_q];

    assign bus.req0_ready = gnt0;
    assign bus.req1_ready = gnt1;
    assign bus.mul_x      = mul_x_q;
    assign bus.mul_y      = mul_y_q;
    assign bus.rsp_valid  = (count_q != '0);
    assign bus.rsp_p      = bus.rsp_valid ? head.p  : '0;
    assign bus.rsp_id     = bus.rsp_valid ? head.id : 1'b0;

    always_comb begin
        rr_d      = rr_q;
        mul_x_d   = mul_x_q;
        mul_y_d   = mul_y_q;
        tag_vld_d = tag_vld_q;
        tag_id_d  = tag_id_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        mem_d     = mem_q;

        if (gnt0) begin
            mul_x_d = bus.req0_x;
            mul_y_d = bus.req0_y;
            rr_d    = 1'b1;
        end else if (gnt1) begin
            mul_x_d = bus.req1_x;
            mul_y_d = bus.req1_y;
            rr_d    = 1'b0;
        end

        tag_vld_d[0] = grant;
        tag_id_d[0]  = gnt1;
        for (int i = 1; i < LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_id_d[i]  = tag_id_q[i-1];
        end

        if (push) begin
            mem_d[wr_ptr_q] = {bus.mul_p, tag_id_q[LATENCY-1]};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + NW'(push) - NW'(pop);
    end

    // Reset discards tags and buffered entries; late multiplier outputs then find no tag and are dropped.
    always_ff @(posedge clock) begin
        if (reset) begin
            rr_q      <= 1'b0;
            mul_x_q   <= '0;
            mul_y_q   <= '0;
            tag_vld_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            rr_q      <= rr_d;
            mul_x_q   <= mul_x_d;
            mul_y_q   <= mul_y_d;
            tag_vld_q <= tag_vld_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        tag_id_q <= tag_id_d;
        mem_q    <= mem_d;
    end

    assert property (@(posedge clock) disable iff (reset)
        !(push && (count_q == NW'(FIFO_DEPTH)) && !pop));

`ifdef RRP_ARB_PERF_CNT_EN
    logic [31:0] issue_cnt_q, issue_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        any_req;

    assign any_req = bus.req0_valid || bus.req1_valid;

    always_comb begin
        issue_cnt_d = issue_cnt_q + 32'(grant);
        stall_cnt_d = stall_cnt_q + 32'(any_req && !credit_ok);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            issue_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign issue_cnt = issue_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    // Counters are not built in the default configuration.
`endif
endmodule
